adder_result_stage: RTL and testbench

//  Registered output stage directly downstream of the N-bit ripple adder.
//  - Captures operands a/b and the adder's combinational sum each cycle a beat is accepted.
//  - Derives carry, overflow, zero and negative flags.
//  - Presents the result on a valid/ready interface with a 2-entry skid buffer, so ALU

---
 rtl/adder_result_stage.sv | 181 ++++++++++++++++++
 tb/tb_adder_result_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_stage.sv
// -----------------------------------------------------------------------------
// adder_result_stage
//   Registered output stage behind the N-bit ripple adder. It captures the
//   operands and the adder's sum, then derives the carry, overflow, zero and
//   negative flags for that beat. Results are presented on a valid/ready
//   interface through a 2-entry skid buffer.
//
//   Optional feature macro: OVF_SATURATE_EN
//     When it is defined, a signed overflow clamps out_sum to the most positive
//     or most negative value.
//     When it is not defined, out_sum wraps around. In that build no clamping
//     logic exists.
// -----------------------------------------------------------------------------
module adder_result_stage #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_carry,
    output logic         out_overflow,
    output logic         out_zero,
    output logic         out_negative
);

    // Occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         in_ready_nxt;
    logic         out_valid_nxt;

    logic         accept_c;
    logic         transfer_c;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;

    // Beat derived from the current inputs
    logic         msb_a_c;
    logic         msb_b_c;
    logic         msb_s_c;
    logic         carry_c;
    logic         ovf_c;
    logic [N-1:0] final_sum_c;
    logic         zero_c;
    logic         neg_c;

    // Skid entry; it is only used while the main entry is stalled
    logic [N-1:0] skid_sum;
    logic         skid_carry;
    logic         skid_overflow;
    logic         skid_zero;
    logic         skid_negative;

    // Flag derivation from the raw operands and the trusted adder sum
    always_comb begin
        msb_a_c = in_a[N-1];
        msb_b_c = in_b[N-1];
        msb_s_c = in_sum[N-1];
        carry_c = (msb_a_c & msb_b_c) | ((msb_a_c ^ msb_b_c) & ~msb_s_c);
        ovf_c   = (msb_a_c == msb_b_c) & (msb_s_c != msb_a_c);
`ifdef OVF_SATURATE_EN
        if (ovf_c) begin
            final_sum_c = msb_a_c ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            final_sum_c = in_sum;
        end
`else
        final_sum_c = in_sum;
`endif
        zero_c = (final_sum_c == '0);
        neg_c  = final_sum_c[N-1];
    end

    // Occupancy state and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next occupancy and the data-steering controls
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        accept_c       = in_valid & in_ready;
        transfer_c     = out_valid & out_ready;

        case (state)
            ST_EMPTY: begin
                if (accept_c) begin
                    load_main_in = 1'b1;
                    state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && transfer_c) begin
                    load_main_in = 1'b1;
                end else if (accept_c) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end else if (transfer_c) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (transfer_c) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase

        // Handshake outputs are registered, so they follow the next state
        in_ready_nxt  = (state_nxt != ST_FULL);
        out_valid_nxt = (state_nxt != ST_EMPTY);
    end

    // Main entry, which drives out_* directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum      <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_negative <= 1'b0;
        end else if (load_main_in) begin
            out_sum      <= final_sum_c;
            out_carry    <= carry_c;
            out_overflow <= ovf_c;
            out_zero     <= zero_c;
            out_negative <= neg_c;
        end else if (load_main_skid) begin
            out_sum      <= skid_sum;
            out_carry    <= skid_carry;
            out_overflow <= skid_overflow;
            out_zero     <= skid_zero;
            out_negative <= skid_negative;
        end
    end

    // Skid entry that catches a beat accepted while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_sum      <= '0;
            skid_carry    <= 1'b0;
            skid_overflow <= 1'b0;
            skid_zero     <= 1'b0;
            skid_negative <= 1'b0;
        end else if (load_skid) begin
            skid_sum      <= final_sum_c;
            skid_carry    <= carry_c;
            skid_overflow <= ovf_c;
            skid_zero     <= zero_c;
            skid_negative <= neg_c;
        end
    end

endmodule

// File: tb/tb_adder_result_stage.sv
// -----------------------------------------------------------------------------
// tb_adder_result_stage
//   Directed vector table for adder_result_stage with N=16.
//   After the table come hand-written sequences for:
//     - backpressure through the skid buffer,
//     - asynchronous reset while the stage is full,
//     - a streaming run at full throughput.
//   Expected values for the sum depend on OVF_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_adder_result_stage;

    localparam int unsigned N = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_sum;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_carry;
    logic         out_overflow;
    logic         out_zero;
    logic         out_negative;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic [15:0] exp_sum;
        logic        exp_c;
        logic        exp_v;
        logic        exp_z;
        logic        exp_n;
    } vec_t;

    vec_t vecs [9];

    adder_result_stage #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sum       (in_sum),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_negative (out_negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sum   = a + b;
    endtask

    // Reference model: wide add for carry, integer range check for overflow
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] wide;
        logic [15:0] s;
        int          sa;
        int          sb;
        int          ss;
        logic        v;
        wide = {1'b0, a} + {1'b0, b};
        s    = wide[15:0];
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        ss   = sa + sb;
        v    = (ss > 32767) || (ss < -32768);
`ifdef OVF_SATURATE_EN
        if (v) s = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
        return {s, wide[16], v, (s == 16'h0000), s[15]};
    endfunction

    initial begin
        logic [19:0] exp;
        logic [15:0] ra;
        logic [15:0] rb;

        //                a        b        sum      exp_sum  c     v     z     n
        vecs[0] = '{16'h1538, 16'h04D2, 16'h1A0A, 16'h1A0A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef OVF_SATURATE_EN
        vecs[2] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[2] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef OVF_SATURATE_EN
        vecs[6] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h4000, 16'h4000, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        vecs[6] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        vecs[8] = '{16'h1234, 16'hEDCC, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);

        // Reset state
        #12;
        check_bit ("rst_out_valid", out_valid, 1'b0);
        check_bit ("rst_in_ready",  in_ready,  1'b1);
        check_word("rst_out_sum",   out_sum,   16'h0000);
        check_bit ("rst_carry",     out_carry, 1'b0);
        rst_n = 1'b1;
        tick();

        // Table: each beat is accepted and appears after its edge
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            in_sum   = vecs[i].sum;
            tick();
            check_bit ($sformatf("v%0d_valid", i), out_valid,    1'b1);
            check_bit ($sformatf("v%0d_ready", i), in_ready,     1'b1);
            check_word($sformatf("v%0d_sum", i),   out_sum,      vecs[i].exp_sum);
            check_bit ($sformatf("v%0d_c", i),     out_carry,    vecs[i].exp_c);
            check_bit ($sformatf("v%0d_v", i),     out_overflow, vecs[i].exp_v);
            check_bit ($sformatf("v%0d_z", i),     out_zero,     vecs[i].exp_z);
            check_bit ($sformatf("v%0d_n", i),     out_negative, vecs[i].exp_n);
        end
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        check_bit("drain_valid", out_valid, 1'b0);

        // Backpressure: fill main and skid, hold the third beat, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 16'h0000);
        tick();
        check_bit ("bp1_ready", in_ready,  1'b1);
        check_bit ("bp1_valid", out_valid, 1'b1);
        check_word("bp1_sum",   out_sum,   16'h0001);
        drive(1'b1, 16'h0002, 16'h0000);
        tick();
        check_bit ("bp2_ready", in_ready, 1'b0);
        check_word("bp2_sum",   out_sum,  16'h0001);
        drive(1'b1, 16'h0003, 16'h0000);
        tick();
        check_bit ("bp3_ready", in_ready,  1'b0);
        check_bit ("bp3_valid", out_valid, 1'b1);
        check_word("bp3_hold",  out_sum,   16'h0001);
        out_ready = 1'b1;
        tick();
        check_word("bp_out2",      out_sum,  16'h0002);
        check_bit ("bp_out2_rdy",  in_ready, 1'b1);
        tick();
        check_word("bp_out3",       out_sum,   16'h0003);
        check_bit ("bp_out3_valid", out_valid, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        check_bit("bp_empty", out_valid, 1'b0);

        // Async reset while full: everything clears before any edge
        out_ready = 1'b0;
        drive(1'b1, 16'hFFFF, 16'h0001);
        tick();
        drive(1'b1, 16'h7FFF, 16'h0001);
        tick();
        check_bit("full_ready", in_ready,  1'b0);
        check_bit("full_zero",  out_zero,  1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit ("arst_valid", out_valid,    1'b0);
        check_bit ("arst_ready", in_ready,     1'b1);
        check_word("arst_sum",   out_sum,      16'h0000);
        check_bit ("arst_c",     out_carry,    1'b0);
        check_bit ("arst_v",     out_overflow, 1'b0);
        check_bit ("arst_z",     out_zero,     1'b0);
        check_bit ("arst_n",     out_negative, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000);
        #2;
        rst_n = 1'b1;
        tick();
        check_bit("post_rst_valid", out_valid, 1'b0);
        check_bit("post_rst_ready", in_ready,  1'b1);

        // Streaming: one beat per cycle with no stall
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive(1'b1, ra, rb);
            exp = model(ra, rb);
            tick();
            check_bit ($sformatf("s%0d_ready", i), in_ready,     1'b1);
            check_bit ($sformatf("s%0d_valid", i), out_valid,    1'b1);
            check_word($sformatf("s%0d_sum", i),   out_sum,      exp[19:4]);
            check_bit ($sformatf("s%0d_c", i),     out_carry,    exp[3]);
            check_bit ($sformatf("s%0d_v", i),     out_overflow, exp[2]);
            check_bit ($sformatf("s%0d_z", i),     out_zero,     exp[1]);
            check_bit ($sformatf("s%0d_n", i),     out_negative, exp[0]);
        end
        drive(1'b0, 16'h0000, 16'h0000);
        tick();
        check_bit("end_empty", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
